// File: rtl/gray_pkg.sv
// Shared Gray-code rules for the conversion paths and the pointer.
// Functions work on MaxWidth-wide zero-extended words; callers truncate to Width.
package gray_pkg;

  localparam int MaxWidth = 32;

  // Upper zero bits do not disturb either rule, so one MaxWidth-wide
  // definition serves every Width from 1 to MaxWidth.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] v);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = v[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ v[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_unit_if.sv
// Bundle of the conversion paths and pointer signals of gray_code_unit.
// Valid semantics: there is no ready; a *_valid input is consumed on every rising
// clk edge it is high, and the matching *_q_valid is high for exactly the cycle after.
interface gray_code_unit_if #(
  parameter int Width = 4
);
  logic [Width-1:0] bin_d;
  logic             bin_valid;
  logic [Width-1:0] gray_q;
  logic             gray_q_valid;
  logic [Width-1:0] gray_d;
  logic             gray_valid;
  logic [Width-1:0] bin_q;
  logic             bin_q_valid;
  logic             inc;
  logic [Width-1:0] ptr_gray;
  logic [Width-1:0] ptr_bin;
  logic [Width-1:0] ptr_gray_next;

  modport master (
    output bin_d, bin_valid, gray_d, gray_valid, inc,
    input  gray_q, gray_q_valid, bin_q, bin_q_valid, ptr_gray, ptr_bin, ptr_gray_next
  );

  modport slave (
    input  bin_d, bin_valid, gray_d, gray_valid, inc,
    output gray_q, gray_q_valid, bin_q, bin_q_valid, ptr_gray, ptr_bin, ptr_gray_next
  );
endinterface

// File: rtl/gray_ptr.sv
// Gray-coded pointer register with combinational binary decode and successor.
// ptr_gray comes straight from the flop so synchronisers never see decode glitches.
module gray_ptr
  import gray_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [Width-1:0] ptr_gray,
  output logic [Width-1:0] ptr_bin,
  output logic [Width-1:0] ptr_gray_next
);

  logic [Width-1:0] ptr_bin_inc;

  assign ptr_bin       = Width'(gray2bin(MaxWidth'(ptr_gray)));
  // Natural modulo-2^Width wrap of the binary add gives the single-bit wrap step.
  assign ptr_bin_inc   = ptr_bin + Width'(1);
  assign ptr_gray_next = Width'(bin2gray(MaxWidth'(ptr_bin_inc)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_gray <= '0;
    end else if (inc) begin
      ptr_gray <= ptr_gray_next;
    end
  end

endmodule

// File: rtl/gray_code_unit.sv
// Registered binary<->Gray converters plus one Gray pointer for async FIFO use.
// The encode and decode paths are fully independent of each other and of the pointer.
module gray_code_unit
  import gray_pkg::*;
#(
  parameter int Width = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_code_unit_if.slave bus
);

  // Encode path: data register holds when no valid arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gray_q       <= '0;
      bus.gray_q_valid <= 1'b0;
    end else begin
      bus.gray_q_valid <= bus.bin_valid;
      if (bus.bin_valid) begin
        bus.gray_q <= Width'(bin2gray(MaxWidth'(bus.bin_d)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bin_q       <= '0;
      bus.bin_q_valid <= 1'b0;
    end else begin
      bus.bin_q_valid <= bus.gray_valid;
      if (bus.gray_valid) begin
        bus.bin_q <= Width'(gray2bin(MaxWidth'(bus.gray_d)));
      end
    end
  end

  gray_ptr #(
    .Width (Width)
  ) u_ptr (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (bus.inc),
    .ptr_gray      (bus.ptr_gray),
    .ptr_bin       (bus.ptr_bin),
    .ptr_gray_next (bus.ptr_gray_next)
  );

endmodule

// File: tb/tb_gray_code_unit.sv
// Bench for gray_code_unit: Width=4 main instance against a behavioural model,
// plus Width=1/2/4/8 instances for exhaustive round trip and pointer wrap.
module tb_gray_code_unit;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT instances ----------------
  gray_code_unit_if #(.Width(4)) m_if ();
  gray_code_unit #(.Width(4)) dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

  logic [7:0] rt_bin;
  logic [7:0] rt_gray;
  logic       rt_valid;
  logic       rt_inc;
  logic [7:0] rt_gq [4];
  logic [7:0] rt_bq [4];
  logic [7:0] rt_pg [4];
  logic [7:0] rt_pb [4];

  gray_code_unit_if #(.Width(1)) r1_if ();
  gray_code_unit_if #(.Width(2)) r2_if ();
  gray_code_unit_if #(.Width(4)) r4_if ();
  gray_code_unit_if #(.Width(8)) r8_if ();
  gray_code_unit #(.Width(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(r1_if));
  gray_code_unit #(.Width(2)) dut_w2 (.clk(clk), .rst_n(rst_n), .bus(r2_if));
  gray_code_unit #(.Width(4)) dut_w4 (.clk(clk), .rst_n(rst_n), .bus(r4_if));
  gray_code_unit #(.Width(8)) dut_w8 (.clk(clk), .rst_n(rst_n), .bus(r8_if));

  assign r1_if.bin_d = rt_bin[0:0];  assign r1_if.gray_d = rt_gray[0:0];
  assign r2_if.bin_d = rt_bin[1:0];  assign r2_if.gray_d = rt_gray[1:0];
  assign r4_if.bin_d = rt_bin[3:0];  assign r4_if.gray_d = rt_gray[3:0];
  assign r8_if.bin_d = rt_bin;       assign r8_if.gray_d = rt_gray;
  assign r1_if.bin_valid = rt_valid; assign r1_if.gray_valid = rt_valid; assign r1_if.inc = rt_inc;
  assign r2_if.bin_valid = rt_valid; assign r2_if.gray_valid = rt_valid; assign r2_if.inc = rt_inc;
  assign r4_if.bin_valid = rt_valid; assign r4_if.gray_valid = rt_valid; assign r4_if.inc = rt_inc;
  assign r8_if.bin_valid = rt_valid; assign r8_if.gray_valid = rt_valid; assign r8_if.inc = rt_inc;
  assign rt_gq[0] = 8'(r1_if.gray_q);   assign rt_bq[0] = 8'(r1_if.bin_q);
  assign rt_gq[1] = 8'(r2_if.gray_q);   assign rt_bq[1] = 8'(r2_if.bin_q);
  assign rt_gq[2] = 8'(r4_if.gray_q);   assign rt_bq[2] = 8'(r4_if.bin_q);
  assign rt_gq[3] = r8_if.gray_q;       assign rt_bq[3] = r8_if.bin_q;
  assign rt_pg[0] = 8'(r1_if.ptr_gray); assign rt_pb[0] = 8'(r1_if.ptr_bin);
  assign rt_pg[1] = 8'(r2_if.ptr_gray); assign rt_pb[1] = 8'(r2_if.ptr_bin);
  assign rt_pg[2] = 8'(r4_if.ptr_gray); assign rt_pb[2] = 8'(r4_if.ptr_bin);
  assign rt_pg[3] = r8_if.ptr_gray;     assign rt_pb[3] = r8_if.ptr_bin;

  // ---------------- model helpers ----------------
  function automatic logic [7:0] m_gray(input int unsigned v);
    return 8'(v ^ (v >> 1));
  endfunction

  // Decode by searching for the binary value whose encoding matches.
  function automatic logic [7:0] m_bin(input int unsigned g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if (m_gray(b) == 8'(g)) return 8'(b);
    end
    return 8'hff;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the Width=4 instance ----------------
  logic [3:0]  m_gq, m_bq;
  logic        m_gqv, m_bqv;
  int unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gq <= 4'd0; m_gqv <= 1'b0; m_bq <= 4'd0; m_bqv <= 1'b0; m_cnt <= 0;
    end else begin
      m_gqv <= m_if.bin_valid;
      m_bqv <= m_if.gray_valid;
      if (m_if.bin_valid)  m_gq <= 4'(m_gray(m_if.bin_d));
      if (m_if.gray_valid) m_bq <= 4'(m_bin(m_if.gray_d, 4));
      if (m_if.inc)        m_cnt <= (m_cnt + 1) % 16;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [3:0] prev_pg  = 4'd0;
  bit         prev_ok  = 1'b0;

  always @(negedge clk) begin
    chk("gray_q",        m_if.gray_q,        m_gq);
    chk("gray_q_valid",  m_if.gray_q_valid,  m_gqv);
    chk("bin_q",         m_if.bin_q,         m_bq);
    chk("bin_q_valid",   m_if.bin_q_valid,   m_bqv);
    chk("ptr_gray",      m_if.ptr_gray,      4'(m_gray(m_cnt)));
    chk("ptr_bin",       m_if.ptr_bin,       4'(m_cnt));
    chk("ptr_gray_next", m_if.ptr_gray_next, 4'(m_gray((m_cnt + 1) % 16)));
    if (prev_ok && rst_n && (m_if.ptr_gray !== prev_pg))
      chk("ptr_step_one_bit", $countones(m_if.ptr_gray ^ prev_pg), 1);
    prev_pg = m_if.ptr_gray;
    prev_ok = rst_n;
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] enc_in  [4] = '{4'b0101, 4'b1111, 4'b0000, 4'b1000};
  logic [3:0] enc_exp [4] = '{4'b0111, 4'b1000, 4'b0000, 4'b1100};
  logic [3:0] dec_in  [4] = '{4'b0111, 4'b1000, 4'b1100, 4'b0001};
  logic [3:0] dec_exp [4] = '{4'b0101, 4'b1111, 4'b1000, 4'b0001};
  logic [1:0] wrap_g  [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
  logic [1:0] wrap_b  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  int         widths  [4] = '{1, 2, 4, 8};

  task automatic main_idle();
    m_if.bin_d = '0; m_if.bin_valid = 1'b0;
    m_if.gray_d = '0; m_if.gray_valid = 1'b0;
    m_if.inc = 1'b0;
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, "_gray_q"},   m_if.gray_q, 0);
    chk({tag, "_gq_valid"}, m_if.gray_q_valid, 0);
    chk({tag, "_bin_q"},    m_if.bin_q, 0);
    chk({tag, "_bq_valid"}, m_if.bin_q_valid, 0);
    chk({tag, "_ptr_gray"}, m_if.ptr_gray, 0);
    chk({tag, "_ptr_bin"},  m_if.ptr_bin, 0);
    chk({tag, "_ptr_next"}, m_if.ptr_gray_next, 4'b0001);
  endtask

  initial begin
    logic [7:0] prev;
    rst_n = 1'b1;
    main_idle();
    rt_bin = '0; rt_gray = '0; rt_valid = 1'b0; rt_inc = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_main_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pointer wrap on the Width=2 instance.
    rt_inc = 1'b1;
    prev = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wrap_ptr_gray", rt_pg[1], 8'(wrap_g[i]));
      chk("wrap_ptr_bin",  rt_pb[1], 8'(wrap_b[i]));
      chk("wrap_one_bit",  $countones(rt_pg[1] ^ prev), 1);
      prev = rt_pg[1];
    end
    rt_inc = 1'b0;

    // Encode / decode vectors, both paths active together.
    m_if.bin_valid = 1'b1; m_if.gray_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_if.bin_d = enc_in[i]; m_if.gray_d = dec_in[i];
      @(negedge clk);
      chk("enc_vec", m_if.gray_q, enc_exp[i]);
      chk("enc_vld", m_if.gray_q_valid, 1);
      chk("dec_vec", m_if.bin_q, dec_exp[i]);
      chk("dec_vld", m_if.bin_q_valid, 1);
    end
    m_if.bin_valid = 1'b0; m_if.gray_valid = 1'b0;
    m_if.bin_d = 4'b0011; m_if.gray_d = 4'b0110;
    @(negedge clk);
    chk("enc_hold",    m_if.gray_q, 4'b1100);
    chk("enc_vld_low", m_if.gray_q_valid, 0);
    chk("dec_hold",    m_if.bin_q, 4'b0001);
    chk("dec_vld_low", m_if.bin_q_valid, 0);

    // Exhaustive round trip for Width 1, 2, 4, 8 (last step re-drives 0 for the wrap pair).
    rt_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v <= (1 << widths[k]); v++) begin
        int unsigned val;
        val = v % (1 << widths[k]);
        rt_bin = 8'(val); rt_gray = m_gray(val);
        @(negedge clk);
        chk("rt_encode", rt_gq[k], m_gray(val));
        chk("rt_decode", rt_bq[k], 8'(val));
        if (v > 0) chk("rt_adjacent_one_bit", $countones(rt_gq[k] ^ prev), 1);
        prev = rt_gq[k];
      end
    end
    rt_valid = 1'b0;

    // Reset asserted mid-run with everything active.
    m_if.inc = 1'b1; m_if.bin_valid = 1'b1; m_if.gray_valid = 1'b1;
    m_if.bin_d = 4'b1010; m_if.gray_d = 4'b0110;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_main_zero("async_rst");
    @(negedge clk);
    chk_main_zero("held_rst");
    rst_n = 1'b1;
    m_if.bin_valid = 1'b0; m_if.gray_valid = 1'b0;
    @(negedge clk);
    chk("first_inc_after_rst", m_if.ptr_gray, 4'b0001);
    m_if.inc = 1'b0;

    // Concurrent random traffic; model tracks pointer holds and independent paths.
    for (int i = 0; i < 300; i++) begin
      m_if.inc        = 1'($urandom_range(0, 1));
      m_if.bin_valid  = 1'($urandom_range(0, 1));
      m_if.gray_valid = 1'($urandom_range(0, 1));
      m_if.bin_d      = 4'($urandom_range(0, 15));
      m_if.gray_d     = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    main_idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
